// File: rtl/inverse_permutation_if.sv
// Slice stream bundle for the inverse permutation stage: input slice handshake,
// decoded output handshake, and matrix-level control/status.
interface inverse_permutation_if #(
    parameter int unsigned N  = 25,
    parameter int unsigned CW = 6
);
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_slice;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_slice;
    logic [CW-1:0] out_index;
    logic          busy;
    logic          done;

    // Driver side: slice reader upstream and consumer downstream.
    modport master (
        output start, in_valid, in_slice, out_ready,
        input  in_ready, out_valid, out_slice, out_index, busy, done
    );

    // Block side.
    modport slave (
        input  start, in_valid, in_slice, out_ready,
        output in_ready, out_valid, out_slice, out_index, busy, done
    );
endinterface

// File: rtl/inverse_permutation.sv
// Decoder-side inverse of the 5x5 lane permutation. Takes one matrix of DEPTH
// slices after a start pulse, un-permutes each slice and presents it on a
// registered valid/ready output; done pulses once the last slice is delivered.
// Lane (a,b) lives at bit 5*b+a; the lane mapping is hard-wired for N = 25.
module inverse_permutation #(
    parameter int unsigned N     = 25,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CW    = 6
) (
    input logic                 clk,
    input logic                 rst,
    inverse_permutation_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] in_count_q, in_count_d;
    logic [CW-1:0] out_index_q, out_index_d;
    logic [N-1:0]  out_slice_q, out_slice_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;

    logic [N-1:0]  slice_inv;
    logic          accept;
    logic          out_hs;
    logic          last_slice;

    // Inverse lane mapping: out lane (x,y) takes in lane (y, (2x+3y) mod 5).
    always_comb begin
        slice_inv = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                slice_inv[5*y+x] = bus.in_slice[5*((2*x+3*y)%5)+y];
            end
        end
    end

    // Input is only taken in RUN, and only when the output register frees up.
    assign bus.in_ready = (state_q == StRun) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign out_hs       = out_valid_q && bus.out_ready;
    assign last_slice   = (in_count_q == CW'(DEPTH - 1));

    // Next-state for the FSM, slice counter and output register.
    always_comb begin
        state_d     = state_q;
        in_count_d  = in_count_q;
        out_index_d = out_index_q;
        out_slice_d = out_slice_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A start coinciding with done is honoured here as well.
                if (bus.start) begin
                    state_d    = StRun;
                    in_count_d = '0;
                end
            end
            StRun: begin
                if (accept) begin
                    out_slice_d = slice_inv;
                    out_index_d = in_count_q;
                    out_valid_d = 1'b1;
                    if (last_slice) begin
                        // Counter parks at DEPTH-1; DRAIN prevents any wrap.
                        state_d = StDrain;
                    end else begin
                        in_count_d = in_count_q + CW'(1);
                    end
                end else if (out_hs) begin
                    out_valid_d = 1'b0;
                end
            end
            StDrain: begin
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // All state registers; asynchronous clear discards any partial matrix.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            in_count_q  <= '0;
            out_index_q <= '0;
            out_slice_q <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_count_q  <= in_count_d;
            out_index_q <= out_index_d;
            out_slice_q <= out_slice_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_slice = out_slice_q;
    assign bus.out_index = out_index_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != StIdle);

endmodule
